// File: rtl/ps2_keystroke_decoder.sv
// PS/2 keyboard receiver that turns make/break scan codes into the 5-bit Tron
// direction code, holding the last pressed mapped key until it is released.
module ps2_keystroke_decoder #(
  parameter int FILTER_LEN     = 4,
  parameter int TIMEOUT_CYCLES = 20000
) (
  input  logic       clkout,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [4:0] keystroke,
  output logic       key_valid,
  output logic       frame_error
);

  localparam int FLT_W = $clog2(FILTER_LEN + 1);
  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [4:0] IDLE_CODE = 5'h1F;

  // Returns {mapped, code}; extended (E0) codes are only the four arrow keys.
  function automatic logic [5:0] map_key(input logic [7:0] code, input logic ext);
    logic [5:0] r;
    r = {1'b0, IDLE_CODE};
    if (ext) begin
      case (code)
        8'h75:   r = {1'b1, 5'd4};
        8'h72:   r = {1'b1, 5'd5};
        8'h6B:   r = {1'b1, 5'd6};
        8'h74:   r = {1'b1, 5'd7};
        default: r = {1'b0, IDLE_CODE};
      endcase
    end else begin
      case (code)
        8'h1D:   r = {1'b1, 5'd0};
        8'h1B:   r = {1'b1, 5'd1};
        8'h1C:   r = {1'b1, 5'd2};
        8'h23:   r = {1'b1, 5'd3};
        8'h29:   r = {1'b1, 5'd8};
        default: r = {1'b0, IDLE_CODE};
      endcase
    end
    return r;
  endfunction

  function automatic logic odd_ones(input logic [8:0] v);
    return ^v;
  endfunction

  logic             clk_meta_r, clk_sync_r, data_meta_r, data_sync_r;
  logic             clk_filt_r;
  logic [FLT_W-1:0] filt_cnt_r;
  logic [3:0]       bit_cnt_r;
  logic [9:0]       shift_r;
  logic [TO_W-1:0]  to_cnt_r;
  logic             ext_r, brk_r;
  logic [4:0]       keystroke_r;
  logic             key_valid_r, frame_error_r;

  logic             flt_done_s, strobe_s, last_bit_s, frame_ok_s, timeout_s;
  logic [5:0]       map_s;

  // Filter/strobe detection, frame checks and key lookup.
  always_comb begin
    flt_done_s = (clk_sync_r != clk_filt_r) && (filt_cnt_r == FLT_W'(FILTER_LEN - 1));
    strobe_s   = flt_done_s && clk_filt_r;
    last_bit_s = (bit_cnt_r == 4'd10);
    frame_ok_s = (shift_r[0] == 1'b0) && data_sync_r && odd_ones(shift_r[9:1]);
    map_s      = map_key(shift_r[8:1], ext_r);
    timeout_s  = (bit_cnt_r != 4'd0) && (to_cnt_r == TO_W'(TIMEOUT_CYCLES - 1));
  end

  // Synchronizers and glitch filter on the keyboard clock; lines idle high.
  always_ff @(posedge clkout) begin
    if (reset) begin
      clk_meta_r  <= 1'b1;
      clk_sync_r  <= 1'b1;
      data_meta_r <= 1'b1;
      data_sync_r <= 1'b1;
      clk_filt_r  <= 1'b1;
      filt_cnt_r  <= '0;
    end else begin
      clk_meta_r  <= ps2_clk;
      clk_sync_r  <= clk_meta_r;
      data_meta_r <= ps2_data;
      data_sync_r <= data_meta_r;
      if (clk_sync_r == clk_filt_r) begin
        filt_cnt_r <= '0;
      end else if (flt_done_s) begin
        clk_filt_r <= clk_sync_r;
        filt_cnt_r <= '0;
      end else begin
        filt_cnt_r <= filt_cnt_r + FLT_W'(1);
      end
    end
  end

  // Bit collection; the stop bit is checked live on the 11th strobe.
  always_ff @(posedge clkout) begin
    if (reset) begin
      bit_cnt_r <= 4'd0;
      shift_r   <= 10'd0;
      to_cnt_r  <= '0;
    end else if (strobe_s) begin
      to_cnt_r <= '0;
      if (last_bit_s) begin
        bit_cnt_r <= 4'd0;
      end else begin
        bit_cnt_r <= bit_cnt_r + 4'd1;
        shift_r   <= {data_sync_r, shift_r[9:1]};
      end
    end else if (bit_cnt_r == 4'd0) begin
      to_cnt_r <= '0;
    end else if (timeout_s) begin
      bit_cnt_r <= 4'd0;
      to_cnt_r  <= '0;
    end else begin
      to_cnt_r <= to_cnt_r + TO_W'(1);
    end
  end

  // Prefix tracking and make/break handling of each completed frame.
  always_ff @(posedge clkout) begin
    if (reset) begin
      keystroke_r   <= IDLE_CODE;
      key_valid_r   <= 1'b0;
      frame_error_r <= 1'b0;
      ext_r         <= 1'b0;
      brk_r         <= 1'b0;
    end else begin
      key_valid_r   <= 1'b0;
      frame_error_r <= 1'b0;
      if (strobe_s && last_bit_s) begin
        if (!frame_ok_s) begin
          frame_error_r <= 1'b1;
          ext_r         <= 1'b0;
          brk_r         <= 1'b0;
        end else if (shift_r[8:1] == 8'hE0) begin
          ext_r <= 1'b1;
        end else if (shift_r[8:1] == 8'hF0) begin
          brk_r <= 1'b1;
        end else begin
          ext_r <= 1'b0;
          brk_r <= 1'b0;
          if (map_s[5]) begin
            if (!brk_r) begin
              keystroke_r <= map_s[4:0];
              key_valid_r <= 1'b1;
            end else if (map_s[4:0] == keystroke_r) begin
              keystroke_r <= IDLE_CODE;
            end
          end
        end
      end
    end
  end

  assign keystroke   = keystroke_r;
  assign key_valid   = key_valid_r;
  assign frame_error = frame_error_r;

endmodule

// File: tb/tb_ps2_keystroke_decoder.sv
// Directed bench: bit-bangs PS/2 frames and checks output pulses against a
// scoreboard of expected key/error events plus the held keystroke value.
module tb_ps2_keystroke_decoder;

  logic       clkout = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [4:0] keystroke;
  logic       key_valid;
  logic       frame_error;

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [6:0] exp_q[$];
  logic [4:0] exp_ks = 5'h1F;
  logic [6:0] got_ev, exp_ev;
  logic       kv_prev = 1'b0;
  logic       fe_prev = 1'b0;

  ps2_keystroke_decoder dut (
    .clkout      (clkout),
    .reset       (reset),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .keystroke   (keystroke),
    .key_valid   (key_valid),
    .frame_error (frame_error)
  );

  always #5 clkout = ~clkout;

  // Pulse monitor: every pulse must match the oldest expected event.
  initial begin
    forever begin
      @(negedge clkout);
      if (key_valid || frame_error) begin
        n_cmp++;
        assert ((kv_prev && key_valid) === 1'b0 && (fe_prev && frame_error) === 1'b0) else begin
          n_bad++;
          $error("FAIL pulse_width observed kv=%0b/%0b fe=%0b/%0b required single-cycle",
                 kv_prev, key_valid, fe_prev, frame_error);
        end
        got_ev = {key_valid, frame_error, keystroke};
        n_cmp++;
        assert ((exp_q.size() > 0) === 1'b1) else begin
          n_bad++;
          $error("FAIL unexpected_pulse observed ev=%h required none", got_ev);
        end
        if (exp_q.size() > 0) begin
          exp_ev = exp_q.pop_front();
          n_cmp++;
          assert (got_ev === exp_ev) else begin
            n_bad++;
            $error("FAIL pulse_event observed ev=%h required ev=%h", got_ev, exp_ev);
          end
        end
      end
      kv_prev = key_valid;
      fe_prev = frame_error;
    end
  end

  task automatic ps2_bit(input logic v);
    @(negedge clkout);
    ps2_data = v;
    repeat (10) @(negedge clkout);
    ps2_clk = 1'b0;
    repeat (20) @(negedge clkout);
    ps2_clk = 1'b1;
    repeat (10) @(negedge clkout);
  endtask

  task automatic send(input logic [7:0] b, input logic bad_par, input int nbits);
    logic [10:0] f;
    f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) ps2_bit(f[i]);
    ps2_data = 1'b1;
    repeat (60) @(negedge clkout);
  endtask

  task automatic key(input logic [7:0] b);
    send(b, 1'b0, 11);
  endtask

  task automatic expect_key(input logic [4:0] c);
    exp_q.push_back({2'b10, c});
    exp_ks = c;
  endtask

  task automatic expect_err();
    exp_q.push_back({2'b01, exp_ks});
  endtask

  task automatic check(input string tag);
    for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clkout);
    n_cmp++;
    assert (exp_q.size() === 0) else begin
      n_bad++;
      $error("FAIL %s_pending observed %0d outstanding required 0", tag, exp_q.size());
      exp_q.delete();
    end
    n_cmp++;
    assert (keystroke === exp_ks) else begin
      n_bad++;
      $error("FAIL %s_keystroke observed %h required %h", tag, keystroke, exp_ks);
    end
  endtask

  initial begin
    repeat (3) @(negedge clkout);
    n_cmp++;
    assert ({keystroke, key_valid, frame_error} === {5'h1F, 1'b0, 1'b0}) else begin
      n_bad++;
      $error("FAIL reset_state observed %h/%b/%b required 1f/0/0", keystroke, key_valid, frame_error);
    end
    reset = 1'b0;
    repeat (1000) @(negedge clkout);
    check("idle");

    expect_key(5'h00); key(8'h1D); check("make_1d");
    key(8'hF0); exp_ks = 5'h1F; key(8'h1D); check("break_1d");

    expect_key(5'h04); key(8'hE0); key(8'h75); check("make_e075");
    expect_key(5'h07); key(8'hE0); key(8'h74); check("make_e074");
    key(8'hE0); key(8'hF0); key(8'h75); check("break_old_75");
    key(8'hE0); key(8'hF0); exp_ks = 5'h1F; key(8'h74); check("break_e074");

    expect_err(); send(8'h1D, 1'b1, 11); check("bad_parity");
    key(8'hE0); expect_err(); send(8'h75, 1'b1, 11); key(8'h75); check("ext_cleared");

    expect_key(5'h00); key(8'h1D); expect_key(5'h00); key(8'h1D); check("typematic");
    expect_key(5'h04); key(8'hE0); key(8'h75); check("overlap_new");
    key(8'hF0); key(8'h1D); check("release_older");
    key(8'hE0); key(8'hF0); exp_ks = 5'h1F; key(8'h75); check("release_newer");
    key(8'h15); check("unmapped_make");

    send(8'h1D, 1'b0, 5);
    repeat (20100) @(negedge clkout);
    expect_key(5'h03); key(8'h23); check("timeout");
    key(8'hF0); exp_ks = 5'h1F; key(8'h23); check("break_23");

    expect_key(5'h02); key(8'h1C); check("make_1c");
    send(8'h1D, 1'b0, 5);
    reset = 1'b1;
    @(negedge clkout);
    reset = 1'b0;
    @(negedge clkout);
    exp_ks = 5'h1F;
    n_cmp++;
    assert (keystroke === exp_ks) else begin
      n_bad++;
      $error("FAIL midframe_reset observed %h required %h", keystroke, exp_ks);
    end
    expect_key(5'h08); key(8'h29); check("after_reset_29");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ps2_keystroke_decoder.md
Name: ps2_keystroke_decoder

Overview:
- Receives raw PS/2 keyboard frames and decodes them into the 5-bit KEYSTROKE direction code consumed by the Tron game logic.
- Player 1 uses the arrow keys (codes 4-7); player 2 uses W/S/A/D (codes 0-3).
- Sits between the PS/2 pins and the game timer; the VGA adapter side is unaffected.
- Holds the code of the key currently held down, and returns to the idle code when that key is released.

Parameters:
- FILTER_LEN, 4: number of consecutive identical clkout samples required before a ps2_clk level change is accepted.
- TIMEOUT_CYCLES, 20000: clkout cycles without a ps2_clk falling edge, mid-frame, before the partial frame is discarded.

Ports:
- clkout  input  1  system clock; must be at least 8x the PS/2 clock (i.e. ≥ 200 kHz).
- reset  input  1  synchronous, active-high reset.
- ps2_clk  input  1  raw PS/2 clock from the keyboard (asynchronous).
- ps2_data  input  1  raw PS/2 data from the keyboard (asynchronous).
- keystroke  output  5  decoded key code; 5'h1F means idle.
- key_valid  output  1  one-cycle pulse on every accepted make code of a mapped key.
- frame_error  output  1  one-cycle pulse when a frame is rejected.

Behaviour:
- Clocking/reset: clock clkout; reset is synchronous, active-high. On reset: keystroke=5'h1F, key_valid=0, frame_error=0, bit counter=0, shift register=0, E0/F0 prefix flags cleared, timeout counter=0.
- Input conditioning:
  - ps2_clk and ps2_data each pass through a 2-FF synchronizer.
  - The synchronized ps2_clk is filtered: the filtered level changes only after FILTER_LEN equal samples.
  - A falling edge of the filtered clock is a sample strobe; ps2_data (synchronized) is sampled on that strobe.
- Frame format: 11 bits — start (0), 8 data bits LSB first, odd parity, stop (1). A 4-bit counter tracks bits 0..10.
- Frame accept: on the 11th strobe, accept if start=0, stop=1 and the 9 bits data+parity contain an odd number of ones.
- Frame reject: otherwise pulse frame_error for 1 cycle, discard the byte, clear both prefix flags, reset the counter.
- Timeout: if the counter is nonzero and no strobe occurs for TIMEOUT_CYCLES cycles, reset the counter to 0 silently (no frame_error).
- Byte handling (on the cycle after an accepted frame):
  - 8'hE0 sets ext; 8'hF0 sets brk; neither changes keystroke.
  - Any other byte is a key code, interpreted with the current ext/brk, after which both flags clear.
- Mapping (ext=0): 1D->0 (P2 up), 1B->1 (P2 down), 1C->2 (P2 left), 23->3 (P2 right), 29->8 (space).
- Mapping (ext=1): 75->4 (P1 up), 72->5 (P1 down), 6B->6 (P1 left), 74->7 (P1 right).
- Make (brk=0) of a mapped key:
  - keystroke <= code and key_valid=1 in the same cycle, so latency is 1 clkout after the stop-bit strobe.
  - Typematic repeats of the same key re-pulse key_valid; keystroke is unchanged.
- Make of an unmapped key: no output change, no pulse.
- Break (brk=1):
  - If the mapped code equals the current keystroke, keystroke <= 5'h1F.
  - Otherwise (other key or unmapped), no change.
  - key_valid is never pulsed on a break.
- Overlapping presses: a new make overrides keystroke immediately (last-pressed wins). Releasing the older key afterwards does not clear the newer code.
- Reset mid-frame: the partial frame is lost and keystroke returns to idle; the next frame must start with a fresh start bit.
- Outputs are registered; key_valid and frame_error never stay high for more than 1 cycle.

Test Plan:
- Reset, then drive no PS/2 activity for 1000 cycles -> keystroke=5'h1F, key_valid and frame_error never high.
- Send frame 8'h1D with correct odd parity -> keystroke=5'h00 one cycle after the stop strobe, key_valid pulses once. Then send F0,1D -> keystroke=5'h1F with no key_valid pulse.
- Send E0,75 -> keystroke=5'h04. Send E0,74 -> 5'h07. Send E0,F0,75 -> stays 5'h07. Send E0,F0,74 -> 5'h1F.
- Send 8'h1D with the parity bit inverted -> frame_error pulses once, keystroke unchanged. Send E0 then a bad frame, then 75 -> keystroke unchanged (ext cleared, 75 unmapped without ext).
- Send 5 bits of a frame, idle 20000 cycles, then a full 8'h23 frame -> keystroke=5'h03, no frame_error.
- Hold 8'h1C (keystroke=5'h02), assert reset for 1 cycle mid-way through the next frame -> keystroke=5'h1F. The following complete 8'h29 frame -> keystroke=5'h08.
